// File: rtl/mem_region_router.sv
// Registered address-window router: decodes a CPU virtual address onto NUM_REGIONS windows,
// translates it, and runs a per-region wait-state handshake with a sticky fault record.
module mem_region_router #(
   parameter int NUM_REGIONS = 4,
   parameter int ADDR_W      = 32,
   parameter logic [NUM_REGIONS*ADDR_W-1:0] BASE   = {32'hFFFF0000, 32'h0000B800, 32'h7FFFEFFC, 32'h10010000},
   parameter logic [NUM_REGIONS*ADDR_W-1:0] LIMIT  = {32'hFFFF000C, 32'h0000CACF, 32'h7FFFFFFB, 32'h10010FFF},
   parameter logic [NUM_REGIONS*ADDR_W-1:0] OFFSET = {32'h00000000, 32'h00000000, 32'h00001000, 32'h00000000},
   parameter logic [NUM_REGIONS*4-1:0]      WAIT   = {4'd0, 4'd1, 4'd0, 4'd0},
   localparam int BANK_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [ADDR_W-1:0]      i_virt_addr,
   input  logic                   i_mem_read,
   input  logic                   i_mem_write,
   input  logic                   i_err_clear,
   output logic [ADDR_W-1:0]      o_phys_addr,
   output logic [NUM_REGIONS-1:0] o_mem_enable,
   output logic [BANK_W-1:0]      o_mem_bank,
   output logic                   o_mem_we,
   output logic                   o_ready,
   output logic                   o_stall,
   output logic                   o_invalid_addr,
   output logic                   o_err_sticky,
   output logic [ADDR_W-1:0]      o_err_addr
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_FAULT  = 2'd2;

   logic [1:0]             r_state;
   logic [3:0]             r_cnt;
   logic [ADDR_W-1:0]      r_phys;
   logic [NUM_REGIONS-1:0] r_enable;
   logic [BANK_W-1:0]      r_bank;
   logic                   r_we;
   logic                   r_err_sticky;
   logic [ADDR_W-1:0]      r_err_addr;

   logic                   w_req;
   logic                   w_hit;
   logic [BANK_W-1:0]      w_idx;
   logic [ADDR_W-1:0]      w_phys;
   logic [3:0]             w_wait;
   logic                   w_ready;
   logic                   w_fault_now;

   assign w_req = i_mem_read | i_mem_write;

   // Scan from the highest index down so the lowest matching window is the one left standing.
   always_comb begin
      w_hit  = 1'b0;
      w_idx  = '0;
      w_phys = '0;
      w_wait = '0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if ((i_virt_addr >= BASE[i*ADDR_W +: ADDR_W]) &&
             (i_virt_addr <= LIMIT[i*ADDR_W +: ADDR_W])) begin
            w_hit  = 1'b1;
            w_idx  = BANK_W'(i);
            w_phys = i_virt_addr - BASE[i*ADDR_W +: ADDR_W] + OFFSET[i*ADDR_W +: ADDR_W];
            w_wait = WAIT[i*4 +: 4];
         end
      end
   end

   assign w_ready     = ((r_state == S_ACCESS) && (r_cnt == 4'd0)) || (r_state == S_FAULT);
   assign w_fault_now = (r_state == S_IDLE) && w_req && !w_hit;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= 4'd0;
         r_phys   <= '0;
         r_enable <= '0;
         r_bank   <= '0;
         r_we     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  if (w_hit) begin
                     r_state  <= S_ACCESS;
                     r_phys   <= w_phys;
                     r_enable <= NUM_REGIONS'(1) << w_idx;
                     r_bank   <= w_idx;
                     r_we     <= i_mem_write;
                     r_cnt    <= w_wait;
                  end else begin
                     r_state  <= S_FAULT;
                     r_enable <= '0;
                     r_we     <= 1'b0;
                  end
               end
            end
            S_ACCESS: begin
               if (r_cnt == 4'd0) begin
                  r_state  <= S_IDLE;
                  r_enable <= '0;
                  r_we     <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_FAULT: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // A fault arriving together with err_clear counts as the first fault after the clear.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_err_sticky <= 1'b0;
         r_err_addr   <= '0;
      end else if (w_fault_now) begin
         r_err_sticky <= 1'b1;
         if (!r_err_sticky || i_err_clear) begin
            r_err_addr <= i_virt_addr;
         end
      end else if (i_err_clear) begin
         r_err_sticky <= 1'b0;
         r_err_addr   <= '0;
      end
   end

   assign o_phys_addr    = r_phys;
   assign o_mem_enable   = r_enable;
   assign o_mem_bank     = r_bank;
   assign o_mem_we       = r_we;
   assign o_ready        = w_ready;
   assign o_stall        = w_req & ~w_ready;
   assign o_invalid_addr = (r_state == S_FAULT);
   assign o_err_sticky   = r_err_sticky;
   assign o_err_addr     = r_err_addr;

endmodule

// File: tb/tb_mem_region_router.sv
// Directed bench for mem_region_router: default map instance plus an instance with an
// overlapping window and longer wait states for priority, long-wait and reset-abort cases.
module tb_mem_region_router;

   logic        clk;
   int          n_cmp;
   int          n_fail;

   logic        rst, rd, wr, clr;
   logic [31:0] va;
   logic [31:0] phys, eaddr;
   logic [3:0]  en;
   logic [1:0]  bank;
   logic        we, rdy, stall, inv, sticky;

   logic        b_rst, b_rd, b_wr, b_clr;
   logic [31:0] b_va;
   logic [31:0] b_phys, b_eaddr;
   logic [3:0]  b_en;
   logic [1:0]  b_bank;
   logic        b_we, b_rdy, b_stall, b_inv, b_sticky;

   mem_region_router dut (
      .i_clk(clk), .i_rst(rst), .i_virt_addr(va), .i_mem_read(rd), .i_mem_write(wr),
      .i_err_clear(clr), .o_phys_addr(phys), .o_mem_enable(en), .o_mem_bank(bank),
      .o_mem_we(we), .o_ready(rdy), .o_stall(stall), .o_invalid_addr(inv),
      .o_err_sticky(sticky), .o_err_addr(eaddr)
   );

   mem_region_router #(
      .NUM_REGIONS(4),
      .ADDR_W(32),
      .BASE  ({32'hFFFF0000, 32'h0000B800, 32'h10010000, 32'h10010000}),
      .LIMIT ({32'hFFFF000C, 32'h0000CACF, 32'h10010FFF, 32'h10010FFF}),
      .OFFSET({32'h00000000, 32'h00000000, 32'h00001000, 32'h00000000}),
      .WAIT  ({4'd15, 4'd3, 4'd0, 4'd0})
   ) dut2 (
      .i_clk(clk), .i_rst(b_rst), .i_virt_addr(b_va), .i_mem_read(b_rd), .i_mem_write(b_wr),
      .i_err_clear(b_clr), .o_phys_addr(b_phys), .o_mem_enable(b_en), .o_mem_bank(b_bank),
      .o_mem_we(b_we), .o_ready(b_rdy), .o_stall(b_stall), .o_invalid_addr(b_inv),
      .o_err_sticky(b_sticky), .o_err_addr(b_eaddr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0; n_fail = 0;
      rst = 1'b1; rd = 1'b0; wr = 1'b0; clr = 1'b0; va = '0;
      b_rst = 1'b1; b_rd = 1'b0; b_wr = 1'b0; b_clr = 1'b0; b_va = '0;
      #12;
      chk("rst_phys", phys, 32'h0);
      chk("rst_en", {28'h0, en}, 32'h0);
      chk("rst_bank", {30'h0, bank}, 32'h0);
      chk("rst_we", {31'h0, we}, 32'h0);
      chk("rst_ready", {31'h0, rdy}, 32'h0);
      chk("rst_inv", {31'h0, inv}, 32'h0);
      chk("rst_sticky", {31'h0, sticky}, 32'h0);
      chk("rst_eaddr", eaddr, 32'h0);
      rst = 1'b0; b_rst = 1'b0;
      step();

      // data-segment read, zero wait
      va = 32'h10010010; rd = 1'b1; #1;
      chk("t1_stall_T", {31'h0, stall}, 32'h1);
      chk("t1_en_T", {28'h0, en}, 32'h0);
      step();
      chk("t1_en", {28'h0, en}, 32'h1);
      chk("t1_bank", {30'h0, bank}, 32'h0);
      chk("t1_phys", phys, 32'h00000010);
      chk("t1_ready", {31'h0, rdy}, 32'h1);
      chk("t1_we", {31'h0, we}, 32'h0);
      chk("t1_stall", {31'h0, stall}, 32'h0);
      rd = 1'b0;
      step();
      chk("t1_en_after", {28'h0, en}, 32'h0);
      chk("t1_ready_after", {31'h0, rdy}, 32'h0);

      // stack write with offset
      va = 32'h7FFFF000; wr = 1'b1;
      step();
      chk("t2_en", {28'h0, en}, 32'h2);
      chk("t2_bank", {30'h0, bank}, 32'h1);
      chk("t2_phys", phys, 32'h00001004);
      chk("t2_we", {31'h0, we}, 32'h1);
      chk("t2_ready", {31'h0, rdy}, 32'h1);
      wr = 1'b0;
      step();
      chk("t2_we_after", {31'h0, we}, 32'h0);

      // VGA read, one wait state; address change mid-access is ignored
      va = 32'h0000B804; rd = 1'b1; #1;
      chk("t3_stall_T", {31'h0, stall}, 32'h1);
      step();
      chk("t3_en1", {28'h0, en}, 32'h4);
      chk("t3_bank", {30'h0, bank}, 32'h2);
      chk("t3_phys1", phys, 32'h00000004);
      chk("t3_ready1", {31'h0, rdy}, 32'h0);
      chk("t3_stall1", {31'h0, stall}, 32'h1);
      va = 32'h0000B900;
      step();
      chk("t3_en2", {28'h0, en}, 32'h4);
      chk("t3_phys2", phys, 32'h00000004);
      chk("t3_ready2", {31'h0, rdy}, 32'h1);
      chk("t3_stall2", {31'h0, stall}, 32'h0);
      rd = 1'b0;
      step();
      chk("t3_en_after", {28'h0, en}, 32'h0);
      chk("idle_inv", {31'h0, inv}, 32'h0);

      // unmapped accesses and the sticky error record
      va = 32'h20000000; rd = 1'b1;
      step();
      chk("t4_ready", {31'h0, rdy}, 32'h1);
      chk("t4_inv", {31'h0, inv}, 32'h1);
      chk("t4_en", {28'h0, en}, 32'h0);
      chk("t4_sticky", {31'h0, sticky}, 32'h1);
      chk("t4_eaddr", eaddr, 32'h20000000);
      rd = 1'b0;
      step();
      chk("t4_inv_after", {31'h0, inv}, 32'h0);
      chk("t4_ready_after", {31'h0, rdy}, 32'h0);
      chk("t4_sticky_hold", {31'h0, sticky}, 32'h1);
      va = 32'h00000000; rd = 1'b1;
      step();
      chk("t4b_inv", {31'h0, inv}, 32'h1);
      chk("t4b_eaddr_kept", eaddr, 32'h20000000);
      rd = 1'b0;
      step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("t4_clr_sticky", {31'h0, sticky}, 32'h0);
      chk("t4_clr_eaddr", eaddr, 32'h0);

      // fault and err_clear in the same acceptance cycle
      va = 32'h40000000; rd = 1'b1;
      step();
      rd = 1'b0;
      chk("t4c_eaddr", eaddr, 32'h40000000);
      step();
      va = 32'h50000000; rd = 1'b1; clr = 1'b1;
      step();
      rd = 1'b0; clr = 1'b0;
      chk("t4d_sticky", {31'h0, sticky}, 32'h1);
      chk("t4d_eaddr", eaddr, 32'h50000000);
      chk("t4d_inv", {31'h0, inv}, 32'h1);
      step();

      // back-to-back reads with request held through ready
      va = 32'h10010020; rd = 1'b1;
      step();
      chk("b2b_phys1", phys, 32'h00000020);
      chk("b2b_ready1", {31'h0, rdy}, 32'h1);
      va = 32'h10010030;
      step();
      chk("b2b_gap_ready", {31'h0, rdy}, 32'h0);
      chk("b2b_gap_stall", {31'h0, stall}, 32'h1);
      chk("b2b_gap_en", {28'h0, en}, 32'h0);
      step();
      chk("b2b_phys2", phys, 32'h00000030);
      chk("b2b_ready2", {31'h0, rdy}, 32'h1);
      chk("b2b_en2", {28'h0, en}, 32'h1);
      rd = 1'b0;
      step();

      // overlapping windows: lowest index wins
      b_va = 32'h10010004; b_rd = 1'b1;
      step();
      chk("ovl_en", {28'h0, b_en}, 32'h1);
      chk("ovl_bank", {30'h0, b_bank}, 32'h0);
      chk("ovl_phys", b_phys, 32'h00000004);
      chk("ovl_ready", {31'h0, b_rdy}, 32'h1);
      b_rd = 1'b0;
      step();

      // WAIT=15: sixteen enable cycles, ready on the last
      b_va = 32'hFFFF0008; b_rd = 1'b1;
      for (int k = 0; k < 15; k++) begin
         step();
         chk("w15_en", {28'h0, b_en}, 32'h8);
         chk("w15_ready_lo", {31'h0, b_rdy}, 32'h0);
      end
      step();
      chk("w15_en_last", {28'h0, b_en}, 32'h8);
      chk("w15_bank", {30'h0, b_bank}, 32'h3);
      chk("w15_phys", b_phys, 32'h00000008);
      chk("w15_ready", {31'h0, b_rdy}, 32'h1);
      b_rd = 1'b0;
      step();
      chk("w15_en_after", {28'h0, b_en}, 32'h0);

      // reset in the middle of a WAIT=3 access
      b_va = 32'h0000B810; b_rd = 1'b1;
      step();
      chk("rab_en", {28'h0, b_en}, 32'h4);
      chk("rab_phys", b_phys, 32'h00000010);
      step();
      #3 b_rst = 1'b1;
      #1;
      chk("rab_rst_en", {28'h0, b_en}, 32'h0);
      chk("rab_rst_phys", b_phys, 32'h0);
      chk("rab_rst_bank", {30'h0, b_bank}, 32'h0);
      chk("rab_rst_ready", {31'h0, b_rdy}, 32'h0);
      b_rd = 1'b0;
      step();
      step();
      chk("rab_hold_ready", {31'h0, b_rdy}, 32'h0);
      b_rst = 1'b0;
      step();
      step();
      chk("rab_post_ready", {31'h0, b_rdy}, 32'h0);
      chk("rab_post_en", {28'h0, b_en}, 32'h0);
      b_va = 32'h10010008; b_rd = 1'b1;
      step();
      chk("rab_new_en", {28'h0, b_en}, 32'h1);
      chk("rab_new_phys", b_phys, 32'h00000008);
      chk("rab_new_ready", {31'h0, b_rdy}, 32'h1);
      b_rd = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
